pong_scoreboard: RTL and testbench
==================================

Name: pong_scoreboard

Overview:
- Parametrised score keeper and display driver for N-player Pong.
- Replaces the fixed two-player, single-digit 4-bit score path feeding the seven-segment displays.
- Holds a multi-digit BCD score per player and runs the game state (idle / playing / game over).
- Detects the winner and drives registered seven-segment patterns for every digit, with winner blink during game over.
- Sits between Pong game logic (point pulses, start pulse) and the board seven-segment pins.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8).
- NUM_DIGITS, 2, BCD digits per player score (1..4).
- WIN_SCORE, 11, score that ends the game (binary integer, 0 = never ends, must be <= 10^NUM_DIGITS-1).
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted for common-anode displays.
- BLINK_CYCLES, 12500000, half-period in clocks of winner blink during game over.

Ports:
- i_Clk  in  1  system clock (25 MHz).
- i_Rst  in  1  synchronous reset, active-high.
- i_Game_Start  in  1  single-cycle pulse to start a new game.
- i_Point  in  NUM_PLAYERS  bit p pulses one cycle when player p scores.
- o_Playing  out  1  high in PLAYING state.
- o_Game_Over  out  1  high in GAME_OVER state.
- o_Winner  out  max(1,clog2(NUM_PLAYERS))  winning player index, valid while o_Game_Over.
- o_Score_BCD  out  NUM_PLAYERS*NUM_DIGITS*4  player p digit d at [(p*NUM_DIGITS+d)*4 +: 4], d=0 is the units digit.
- o_Segments  out  NUM_PLAYERS*NUM_DIGITS*7  player p digit d at [(p*NUM_DIGITS+d)*7 +: 7], bit order {G,F,E,D,C,B,A}.

Behaviour:
- Reset (i_Rst=1 at a clock edge) takes effect on that edge, including mid-game:
  - state IDLE, all scores 0, o_Winner 0, blink counter 0, blink phase on.
  - o_Playing 0, o_Game_Over 0.
  - o_Segments shows "0" on every digit, polarity applied, on the next edge.
- State machine:
  - IDLE: i_Game_Start -> PLAYING, scores cleared. i_Point ignored.
  - PLAYING: i_Point increments scores. If any player reaches WIN_SCORE -> GAME_OVER. i_Game_Start restarts: scores cleared, stays PLAYING, and i_Point in that same cycle is ignored.
  - GAME_OVER: i_Point ignored. Scores frozen. i_Game_Start -> PLAYING with scores cleared.
- Scoring:
  - Score register updates on the edge after the i_Point pulse (latency 1).
  - Multiple bits may be set in one cycle; each flagged player increments independently.
  - BCD increment carries from the units digit upward.
  - At all-nines (e.g. 99 with 2 digits), the score saturates and holds.
- Win detection:
  - Compare the next score value against the BCD form of WIN_SCORE.
  - GAME_OVER, o_Winner and frozen scores take effect on the same edge as the winning increment.
  - If several players reach WIN_SCORE in the same cycle, the lowest index wins.
  - WIN_SCORE=0 disables detection; the game never leaves PLAYING except by restart.
- Segment path:
  - One registered stage after the score register: o_Segments lags o_Score_BCD by 1 cycle, i_Point to o_Segments is 2 cycles.
  - Digit values 0-9 use standard patterns; codes 10-15 cannot occur and are driven blank.
  - Leading zeros are displayed, not blanked.
  - SEG_ACTIVE_LOW is applied in the output register.
- Blink:
  - In GAME_OVER the blink counter counts 0..BLINK_CYCLES-1 and toggles the phase on wrap.
  - When the phase is off, the winner's digits are blank (all segments inactive). Other players are always shown.
  - Counter and phase reset to 0/on on entry to GAME_OVER and are held in other states.

Decomposition:
- Shared package:
  - state encoding constants IDLE=0, PLAYING=1, GAME_OVER=2.
  - 7-segment lookup constants for digits 0-9 and blank.
  - localparam function for binary-to-BCD conversion of WIN_SCORE.
- Sub-module bcd_to_7seg (combinational, 4-bit in, 7-bit active-high out).
  - Instantiated NUM_PLAYERS*NUM_DIGITS times via generate.
  - Polarity and blanking are handled in the parent register.

Test Plan:
1. Reset, then i_Game_Start, then 3 pulses on i_Point[0] -> o_Score_BCD player0 = 0x03. o_Segments player0 units = ~7'b1001111 (active-low "3"), 2 cycles after the last pulse.
2. WIN_SCORE=11, drive player1 to 10 then pulse -> on that edge o_Game_Over=1, o_Winner=1, player1 BCD=0x11. Further i_Point changes nothing.
3. Player0 and player1 both at 10, pulse i_Point=2'b11 -> both scores 0x11, o_Winner=0.
4. WIN_SCORE=0, NUM_DIGITS=2, 100 pulses on player0 -> score goes 99 and holds at 0x99, o_Playing stays 1.
5. BLINK_CYCLES=4, in GAME_OVER -> winner digits alternate blank/shown every 4 cycles while other players stay steady. i_Game_Start -> all scores 0, o_Playing=1.
6. i_Rst asserted mid-game with score 0x05 -> next edge: score 0, state IDLE. i_Point while in IDLE -> score remains 0.

Source files
------------

// File: rtl/pong_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_scoreboard_pkg
// Purpose  : Shared types and constants for the Pong scoreboard: game state
//            encoding, seven-segment patterns and a binary-to-BCD helper used
//            to turn the winning score into a digit-comparable constant.
// Revision : 1.0  initial release
// ============================================================================
package pong_scoreboard_pkg;

    // Game state encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    // Seven-segment patterns, active-high, bit order {G,F,E,D,C,B,A}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Converts a binary value (0..9999) into four packed BCD digits,
    // digit 0 in bits [3:0]. Used at elaboration time only.
    function automatic logic [15:0] f_bin_to_bcd(input int value);
        logic [15:0] r_bcd;
        int          v;
        r_bcd = '0;
        v     = value;
        for (int d = 0; d < 4; d++) begin
            r_bcd[d*4 +: 4] = 4'(v % 10);
            v               = v / 10;
        end
        return r_bcd;
    endfunction

endpackage : pong_scoreboard_pkg
`default_nettype wire

// File: rtl/pong_scoreboard_bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_7seg
// Purpose  : Combinational BCD digit to seven-segment decoder, active-high,
//            bit order {G,F,E,D,C,B,A}. Non-decimal codes decode to blank.
// Revision : 1.0  initial release
// ============================================================================
module bcd_to_7seg
    import pong_scoreboard_pkg::*;
(
    input  logic [3:0] i_Bcd,
    output logic [6:0] o_Seg
);

    // Digit lookup; codes 10-15 never occur from a valid BCD score
    always_comb begin
        o_Seg = SEG_BLANK;
        case (i_Bcd)
            4'd0:    o_Seg = SEG_0;
            4'd1:    o_Seg = SEG_1;
            4'd2:    o_Seg = SEG_2;
            4'd3:    o_Seg = SEG_3;
            4'd4:    o_Seg = SEG_4;
            4'd5:    o_Seg = SEG_5;
            4'd6:    o_Seg = SEG_6;
            4'd7:    o_Seg = SEG_7;
            4'd8:    o_Seg = SEG_8;
            4'd9:    o_Seg = SEG_9;
            default: o_Seg = SEG_BLANK;
        endcase
    end

endmodule : bcd_to_7seg
`default_nettype wire

// File: rtl/pong_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : pong_scoreboard
// Purpose  : N-player Pong score keeper. Holds a multi-digit BCD score per
//            player, runs the idle/playing/game-over state machine, detects
//            the winner and drives registered seven-segment patterns with a
//            winner blink while the game is over.
// Revision : 1.0  initial release
// ============================================================================
module pong_scoreboard
    import pong_scoreboard_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int NUM_DIGITS     = 2,
    parameter int WIN_SCORE      = 11,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLINK_CYCLES   = 12500000
) (
    input  logic                                                  i_Clk,
    input  logic                                                  i_Rst,
    input  logic                                                  i_Game_Start,
    input  logic [NUM_PLAYERS-1:0]                                i_Point,
    output logic                                                  o_Playing,
    output logic                                                  o_Game_Over,
    output logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] o_Winner,
    output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0]                   o_Score_BCD,
    output logic [NUM_PLAYERS*NUM_DIGITS*7-1:0]                   o_Segments
);

    localparam int SW = NUM_DIGITS * 4;                 // bits per player score
    localparam int NS = NUM_PLAYERS * NUM_DIGITS;       // total digits
    localparam int WW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [15:0]   c_WIN_BCD_ALL = f_bin_to_bcd(WIN_SCORE);
    localparam logic [SW-1:0] c_WIN_BCD     = c_WIN_BCD_ALL[SW-1:0];
    localparam logic [BW-1:0] c_BLINK_LAST  = BW'(BLINK_CYCLES - 1);
    localparam logic [6:0]    c_ZERO_OUT    = (SEG_ACTIVE_LOW != 0) ? ~SEG_0 : SEG_0;

    // BCD increment with carry from the units digit; all-nines saturates
    function automatic logic [SW-1:0] f_bcd_inc(input logic [SW-1:0] i_Val);
        logic [SW-1:0] v_Res;
        logic          v_Carry;
        logic          v_All9;
        v_Res   = i_Val;
        v_Carry = 1'b1;
        v_All9  = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (i_Val[d*4 +: 4] != 4'd9) begin
                v_All9 = 1'b0;
            end
            if (v_Carry) begin
                if (i_Val[d*4 +: 4] == 4'd9) begin
                    v_Res[d*4 +: 4] = 4'd0;
                end else begin
                    v_Res[d*4 +: 4] = i_Val[d*4 +: 4] + 4'd1;
                    v_Carry         = 1'b0;
                end
            end
        end
        return v_All9 ? i_Val : v_Res;
    endfunction

    state_t                    r_State;
    state_t                    w_State_Next;
    logic [NUM_PLAYERS*SW-1:0] r_Score;
    logic [NUM_PLAYERS*SW-1:0] w_Score_Next;
    logic [NUM_PLAYERS*SW-1:0] w_Score_Cand;
    logic [NUM_PLAYERS-1:0]    w_Hit;
    logic [WW-1:0]             w_Win_Idx;
    logic [WW-1:0]             r_Winner;
    logic [WW-1:0]             w_Winner_Next;
    logic [BW-1:0]             r_Blink_Cnt;
    logic                      r_Blink_On;
    logic                      w_Go_Entry;
    logic [NS*7-1:0]           w_Dec;
    logic [NS*7-1:0]           w_Seg_Next;
    logic [NS*7-1:0]           r_Seg;
    logic [6:0]                w_Pat;

    // Candidate scores after this cycle's points, plus per-player win hits
    always_comb begin
        w_Score_Cand = r_Score;
        w_Hit        = '0;
        w_Win_Idx    = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (i_Point[p]) begin
                w_Score_Cand[p*SW +: SW] = f_bcd_inc(r_Score[p*SW +: SW]);
            end
            w_Hit[p] = (WIN_SCORE != 0) && i_Point[p] &&
                       (f_bcd_inc(r_Score[p*SW +: SW]) == c_WIN_BCD);
        end
        // Scan downward so the lowest-indexed hit ends up selected
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (w_Hit[p]) begin
                w_Win_Idx = WW'(p);
            end
        end
    end

    // Next-state, score and winner logic
    always_comb begin
        w_State_Next  = r_State;
        w_Score_Next  = r_Score;
        w_Winner_Next = r_Winner;
        case (r_State)
            ST_IDLE: begin
                if (i_Game_Start) begin
                    w_State_Next = ST_PLAYING;
                    w_Score_Next = '0;
                end
            end
            ST_PLAYING: begin
                if (i_Game_Start) begin
                    // Restart wins over any point in the same cycle
                    w_Score_Next = '0;
                end else begin
                    w_Score_Next = w_Score_Cand;
                    if (|w_Hit) begin
                        w_State_Next  = ST_GAME_OVER;
                        w_Winner_Next = w_Win_Idx;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (i_Game_Start) begin
                    w_State_Next = ST_PLAYING;
                    w_Score_Next = '0;
                end
            end
            default: begin
                w_State_Next = ST_IDLE;
            end
        endcase
    end

    // State, score and winner registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State  <= ST_IDLE;
            r_Score  <= '0;
            r_Winner <= '0;
        end else begin
            r_State  <= w_State_Next;
            r_Score  <= w_Score_Next;
            r_Winner <= w_Winner_Next;
        end
    end

    assign w_Go_Entry = (w_State_Next == ST_GAME_OVER) && (r_State != ST_GAME_OVER);

    // Winner blink timer: restarts on entering game over, frozen elsewhere
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Blink_Cnt <= '0;
            r_Blink_On  <= 1'b1;
        end else if (w_Go_Entry) begin
            r_Blink_Cnt <= '0;
            r_Blink_On  <= 1'b1;
        end else if ((r_State == ST_GAME_OVER) && (w_State_Next == ST_GAME_OVER)) begin
            if (r_Blink_Cnt == c_BLINK_LAST) begin
                r_Blink_Cnt <= '0;
                r_Blink_On  <= ~r_Blink_On;
            end else begin
                r_Blink_Cnt <= r_Blink_Cnt + BW'(1);
            end
        end
    end

    // One decoder per displayed digit
    for (genvar g = 0; g < NS; g++) begin : g_dec
        bcd_to_7seg u_dec (
            .i_Bcd (r_Score[g*4 +: 4]),
            .o_Seg (w_Dec[g*7 +: 7])
        );
    end

    // Apply winner blanking and output polarity ahead of the segment register
    always_comb begin
        w_Seg_Next = '0;
        w_Pat      = SEG_BLANK;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                w_Pat = w_Dec[(p*NUM_DIGITS + d)*7 +: 7];
                if ((r_State == ST_GAME_OVER) && !r_Blink_On && (r_Winner == WW'(p))) begin
                    w_Pat = SEG_BLANK;
                end
                w_Seg_Next[(p*NUM_DIGITS + d)*7 +: 7] = (SEG_ACTIVE_LOW != 0) ? ~w_Pat : w_Pat;
            end
        end
    end

    // Segment output register; reset shows "0" on every digit
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Seg <= {NS{c_ZERO_OUT}};
        end else begin
            r_Seg <= w_Seg_Next;
        end
    end

    assign o_Playing   = (r_State == ST_PLAYING);
    assign o_Game_Over = (r_State == ST_GAME_OVER);
    assign o_Winner    = r_Winner;
    assign o_Score_BCD = r_Score;
    assign o_Segments  = r_Seg;

endmodule : pong_scoreboard
`default_nettype wire

// File: tb/tb_pong_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_scoreboard
// Purpose  : Scoreboard bench for pong_scoreboard. Two instances share the
//            stimulus: A ends games at 11 with two digits, B never ends and
//            saturates a single digit. A reference model keeps scores as
//            integers and predicts every output each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_pong_scoreboard;

    localparam int NP    = 3;
    localparam int BLINK = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NP-1:0] point = '0;

    logic            pl_a, go_a, pl_b, go_b;
    logic [1:0]      win_a, win_b;
    logic [NP*8-1:0] sc_a;
    logic [NP*14-1:0] sg_a;
    logic [NP*4-1:0] sc_b;
    logic [NP*7-1:0] sg_b;

    pong_scoreboard #(
        .NUM_PLAYERS(NP), .NUM_DIGITS(2), .WIN_SCORE(11),
        .SEG_ACTIVE_LOW(1), .BLINK_CYCLES(BLINK)
    ) u_dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Game_Start(start), .i_Point(point),
        .o_Playing(pl_a), .o_Game_Over(go_a), .o_Winner(win_a),
        .o_Score_BCD(sc_a), .o_Segments(sg_a)
    );

    pong_scoreboard #(
        .NUM_PLAYERS(NP), .NUM_DIGITS(1), .WIN_SCORE(0),
        .SEG_ACTIVE_LOW(1), .BLINK_CYCLES(BLINK)
    ) u_dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Game_Start(start), .i_Point(point),
        .o_Playing(pl_b), .o_Game_Over(go_b), .o_Winner(win_b),
        .o_Score_BCD(sc_b), .o_Segments(sg_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pl0;
        logic        go0;
        logic [1:0]  w0;
        logic [63:0] sc0;
        logic [63:0] sg0;
        logic        pl1;
        logic        go1;
        logic [1:0]  w1;
        logic [63:0] sc1;
        logic [63:0] sg1;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: 0 idle, 1 playing, 2 game over; k = edges since entry
    int m_state [2] = '{0, 0};
    int m_score [2][NP];
    int m_win   [2] = '{0, 0};
    int m_k     [2] = '{0, 0};
    int nd      [2] = '{2, 1};
    int wsc     [2] = '{11, 0};
    logic [6:0] pat_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int j = 0; j < e; j++) r = r * 10;
        return r;
    endfunction

    function automatic void model_step(input int i, input logic r, input logic s,
                                       input logic [NP-1:0] pt,
                                       output logic [63:0] sc, output logic [63:0] sg,
                                       output logic pl, output logic go, output logic [1:0] w);
        int mx, dig, found, idx;
        logic [6:0] p7;
        mx = pow10(nd[i]) - 1;
        sg = '0;
        sc = '0;
        // Display reflects the scores as they stood before this edge
        for (int p = 0; p < NP; p++) begin
            for (int d = 0; d < nd[i]; d++) begin
                idx = p * nd[i] + d;
                if (r) begin
                    p7 = pat_tbl[0];
                end else begin
                    dig = (m_score[i][p] / pow10(d)) % 10;
                    p7  = pat_tbl[dig];
                    if (m_state[i] == 2 && ((m_k[i] / BLINK) % 2) == 1 && p == m_win[i])
                        p7 = 7'h00;
                end
                sg[idx*7 +: 7] = ~p7;
            end
        end
        if (r) begin
            m_state[i] = 0;
            m_win[i]   = 0;
            m_k[i]     = 0;
            for (int p = 0; p < NP; p++) m_score[i][p] = 0;
        end else begin
            case (m_state[i])
                0: if (s) begin
                       m_state[i] = 1;
                       for (int p = 0; p < NP; p++) m_score[i][p] = 0;
                   end
                1: if (s) begin
                       for (int p = 0; p < NP; p++) m_score[i][p] = 0;
                   end else begin
                       found = -1;
                       for (int p = 0; p < NP; p++)
                           if (pt[p] && m_score[i][p] < mx) m_score[i][p]++;
                       for (int p = 0; p < NP; p++)
                           if (found < 0 && pt[p] && wsc[i] != 0 && m_score[i][p] == wsc[i])
                               found = p;
                       if (found >= 0) begin
                           m_state[i] = 2;
                           m_win[i]   = found;
                           m_k[i]     = 0;
                       end
                   end
                default: if (s) begin
                       m_state[i] = 1;
                       for (int p = 0; p < NP; p++) m_score[i][p] = 0;
                   end else begin
                       m_k[i]++;
                   end
            endcase
        end
        for (int p = 0; p < NP; p++)
            for (int d = 0; d < nd[i]; d++)
                sc[(p*nd[i] + d)*4 +: 4] = 4'((m_score[i][p] / pow10(d)) % 10);
        pl = (m_state[i] == 1);
        go = (m_state[i] == 2);
        w  = 2'(m_win[i]);
    endfunction

    // Drive one cycle of stimulus and queue the response expected after the edge
    task automatic cycle(input logic r, input logic s, input logic [NP-1:0] pt);
        exp_t e;
        @(negedge clk);
        rst   = r;
        start = s;
        point = pt;
        model_step(0, r, s, pt, e.sc0, e.sg0, e.pl0, e.go0, e.w0);
        model_step(1, r, s, pt, e.sc1, e.sg1, e.pl1, e.go1, e.w1);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("playing_a",  64'(pl_a), 64'(e.pl0));
            chk("gameover_a", 64'(go_a), 64'(e.go0));
            if (e.go0) chk("winner_a", 64'(win_a), 64'(e.w0));
            chk("score_a",    64'(sc_a), e.sc0);
            chk("segs_a",     64'(sg_a), e.sg0);
            chk("playing_b",  64'(pl_b), 64'(e.pl1));
            chk("gameover_b", 64'(go_b), 64'(e.go1));
            chk("score_b",    64'(sc_b), e.sc1);
            chk("segs_b",     64'(sg_b), e.sg1);
        end
    end

    function automatic logic [NP-1:0] rand_pts();
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p] = ($urandom_range(0, 2) == 0);
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < NP; p++) m_score[i][p] = 0;

        repeat (3) cycle(1'b1, 1'b0, '0);
        repeat (5) cycle(1'b0, 1'b0, rand_pts());        // points ignored in idle
        cycle(1'b0, 1'b1, 3'b111);                       // start, same-cycle points ignored
        repeat (3) cycle(1'b0, 1'b0, 3'b001);            // player0 to 3
        cycle(1'b0, 1'b1, '0);
        repeat (10) cycle(1'b0, 1'b0, 3'b011);           // players 0 and 1 to 10
        cycle(1'b0, 1'b0, 3'b011);                       // tie at 11: lowest index wins
        repeat (12) cycle(1'b0, 1'b0, rand_pts());       // frozen, blinking
        cycle(1'b0, 1'b1, '0);
        repeat (10) cycle(1'b0, 1'b0, 3'b010);
        cycle(1'b0, 1'b0, 3'b010);                       // player1 wins
        repeat (12) cycle(1'b0, 1'b0, 3'b111);
        cycle(1'b0, 1'b1, 3'b111);                       // restart from game over
        repeat (5) cycle(1'b0, 1'b0, 3'b001);
        cycle(1'b1, 1'b0, 3'b001);                       // reset mid-game
        repeat (4) cycle(1'b0, 1'b0, 3'b001);            // idle: no scoring

        for (int n = 0; n < 3000; n++)
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0), rand_pts());

        repeat (2) cycle(1'b0, 1'b0, '0);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pong_scoreboard
`default_nettype wire
